sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Parametrised synchronous FIFO with generalised width, any depth ≥ 2, programmable almost-full/almost-empty levels, an occupancy count output and accepted read+write at full. It is the next-generation storage block behind the FIFO interface bundle. It drives the same flag set (full, almostfull, empty, almostempty, overflow, underflow, wr_ack) plus `count`, and it sits directly between producer and consumer in a single clock domain.

## Interface
- FIFO_WIDTH, 16, data word width in bits (≥ 1)
- FIFO_DEPTH, 8, number of entries (≥ 2; not required to be a power of two)
- AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count ≥ AF_LEVEL and count < FIFO_DEPTH
- AE_LEVEL, 1, almostempty asserts when 0 < count ≤ AE_LEVEL
- Parameter legality: 1 ≤ AE_LEVEL < AF_LEVEL ≤ FIFO_DEPTH-1; elaboration error otherwise
- CW (localparam), $clog2(FIFO_DEPTH+1), count width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_in  input  FIFO_WIDTH  write data
- data_out  output  FIFO_WIDTH  registered read data
- full  output  1  count == FIFO_DEPTH
- almostfull  output  1  per AF_LEVEL
- empty  output  1  count == 0
- almostempty  output  1  per AE_LEVEL
- overflow  output  1  registered; previous-cycle write was rejected
- underflow  output  1  registered; previous-cycle read was rejected
- wr_ack  output  1  registered; previous-cycle write was accepted
- count  output  CW  current occupancy, 0..FIFO_DEPTH

## Operation
- Storage: FIFO_DEPTH × FIFO_WIDTH array, write pointer wp, read pointer rp, and occupancy register cnt.
- Pointer wrap: explicit wrap from FIFO_DEPTH-1 to 0, which is valid for non-power-of-two depths.
- Write accepted (wa) = wr_en && (!full || rd_en): at full, a simultaneous read frees the slot.
- Read accepted (ra) = rd_en && !empty. At empty, a simultaneous write is accepted, the read is rejected and underflow is raised. There is no fall-through.
- On wa: mem[wp] ← data_in, wp advances.
- On ra: data_out ← mem[rp], rp advances.
- cnt update: +1 if wa && !ra; −1 if ra && !wa; unchanged if both or neither.
- wr_ack ← wa; overflow ← wr_en && !wa; underflow ← rd_en && !ra.
- Flags full, almostfull, empty, almostempty and count are decoded from cnt only. They are registered-state derived, with no combinational path from wr_en or rd_en.
- Reset (rst_n = 0 at an edge): wp = rp = cnt = 0, data_out = 0, wr_ack = overflow = underflow = 0. Result: empty = 1 and full = almostfull = almostempty = 0. Memory contents are not cleared.
- Reset has priority over a same-cycle wr_en/rd_en. Reset mid-operation discards all stored data.

## Timing
- Write latency: data written at edge N is readable by a rd_en sampled at edge N+1.
- Read latency: rd_en sampled at edge N gives data_out valid after edge N, and it holds until the next accepted read or reset.
- wr_ack, overflow and underflow are single-cycle pulses, valid the cycle after the request. They are recomputed every edge.
- Flags and count reflect cnt after edge N. Exact boundary points: full at cnt = FIFO_DEPTH, empty at cnt = 0. No early or late assertion is permitted.
- Simultaneous wr/rd at cnt = FIFO_DEPTH: both accepted, full stays 1, wr_ack = 1, overflow = 0.
- Simultaneous wr/rd at cnt = 0: write accepted, cnt → 1, wr_ack = 1, underflow = 1, data_out unchanged.
- Throughput is one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_ASSERT_EN defined: the embedded SVA property set is compiled in. It checks:
  - !(full && empty)
  - cnt ≤ FIFO_DEPTH
  - count increments/decrements match wa/ra
  - no cnt change on overflow or underflow
  - all outputs at reset values the cycle after rst_n = 0
  - cover points for full, empty, and both simultaneous-access corner cases
- SYNC_FIFO_ASSERT_EN undefined: no assertions or covers are compiled. RTL behaviour is identical.

## Test plan
- Reset, then 8 writes of 0xA000..0xA007 at DEPTH = 8: wr_ack = 1 each cycle; almostfull at count = 7; full at count = 8. A 9th write gives overflow = 1 and count stays 8.
- Drain from full with 8 reads: data_out = 0xA000..0xA007 in order; almostempty at count = 1; empty at count = 0. A 9th read gives underflow = 1 and data_out holds 0xA007.
- At full, wr_en = rd_en = 1 with data_in = 0xBEEF for 3 cycles: full stays 1, overflow = 0, wr_ack = 1, count = 8. Subsequent drain ends with 0xBEEF.
- At empty, wr_en = rd_en = 1 with data_in = 0x1234: count = 1, wr_ack = 1, underflow = 1. The next read returns 0x1234.
- FIFO_DEPTH = 5, AF_LEVEL = 3, AE_LEVEL = 2: run 12 write/read cycles crossing the pointer wrap. Data order is preserved; almostfull at count 3–4 and almostempty at count 1–2.
- Write 4 words, then rst_n = 0 for 1 cycle with wr_en = rd_en = 1: count = 0, empty = 1, wr_ack = 0, data_out = 0. The next write/read round-trips correctly.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: parametrised synchronous FIFO with programmable almost flags, count and read+write at full.
// Define SYNC_FIFO_ASSERT_EN to compile in the embedded SVA checks and covers.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL = FIFO_DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  wr_ack,
  output logic [CW-1:0]         count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 2 || AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH - 1)
    $error("sync_fifo_prog: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wa, ra;
  assign full        = cnt == CW'(FIFO_DEPTH);
  assign empty       = cnt == '0;
  assign almostfull  = cnt >= CW'(AF_LEVEL) && !full;
  assign almostempty = !empty && cnt <= CW'(AE_LEVEL);
  assign count       = cnt;
  // at full, a same-cycle read frees the slot the write lands in
  assign wa = wr_en && (!full || rd_en);
  assign ra = rd_en && !empty;
  always_ff @(posedge clk)
    if (rst_n && wa) mem[wp] <= data_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (ra) begin
        data_out <= mem[rp];
        rp       <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
      end
      cnt       <= (wa && !ra) ? cnt + 1'b1 : (ra && !wa) ? cnt - 1'b1 : cnt;
      wr_ack    <= wa;
      overflow  <= wr_en && !wa;
      underflow <= rd_en && !ra;
    end
  end
`ifdef SYNC_FIFO_ASSERT_EN
  a_not_full_empty: assert property (@(posedge clk) !(full && empty));
  a_cnt_range: assert property (@(posedge clk) cnt <= CW'(FIFO_DEPTH));
  a_cnt_inc: assert property (@(posedge clk) disable iff (!rst_n)
    (wa && !ra) |=> cnt == $past(cnt) + 1'b1);
  a_cnt_dec: assert property (@(posedge clk) disable iff (!rst_n)
    (ra && !wa) |=> cnt == $past(cnt) - 1'b1);
  a_cnt_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (wa == ra) |=> cnt == $past(cnt));
  a_ovf_hold: assert property (@(posedge clk) disable iff (!rst_n)
    overflow |-> cnt == $past(cnt) || $past(ra));
  a_udf_hold: assert property (@(posedge clk) disable iff (!rst_n)
    underflow |-> cnt == $past(cnt) || $past(wa));
  a_reset: assert property (@(posedge clk) !rst_n |=>
    cnt == '0 && data_out == '0 && !wr_ack && !overflow && !underflow && empty);
  c_full: cover property (@(posedge clk) full);
  c_empty: cover property (@(posedge clk) empty);
  c_rw_full: cover property (@(posedge clk) rst_n && full && wr_en && rd_en);
  c_rw_empty: cover property (@(posedge clk) rst_n && empty && wr_en && rd_en);
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed + random checks of sync_fifo_prog (depth 8 and depth 5) against a queue model.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8_n, wr8, rd8, full8, af8, em8, ae8, ov8, un8, ack8;
  logic [15:0] din8, dout8;
  logic [3:0] cnt8;
  logic rst5_n, wr5, rd5, full5, af5, em5, ae5, ov5, un5, ack5;
  logic [15:0] din5, dout5;
  logic [2:0] cnt5;
  int vectors = 0, miscompares = 0;
  logic [15:0] q8[$], q5[$];
  logic [15:0] ed8 = '0, ed5 = '0;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .wr_en(wr8), .rd_en(rd8), .data_in(din8), .data_out(dout8),
    .full(full8), .almostfull(af8), .empty(em8), .almostempty(ae8),
    .overflow(ov8), .underflow(un8), .wr_ack(ack8), .count(cnt8));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut5 (
    .clk(clk), .rst_n(rst5_n), .wr_en(wr5), .rd_en(rd5), .data_in(din5), .data_out(dout5),
    .full(full5), .almostfull(af5), .empty(em5), .almostempty(ae5),
    .overflow(ov5), .underflow(un5), .wr_ack(ack5), .count(cnt5));

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic step(input bit s, input bit w, input bit r, input logic [15:0] din, input bit rst);
    logic [15:0] mq[$];
    logic [15:0] ed;
    int d, af, ae, n;
    bit wa, ra, e_ack, e_ov, e_un;
    string p;
    wr8 = 0; rd8 = 0; wr5 = 0; rd5 = 0; rst8_n = 1; rst5_n = 1;
    if (s) begin
      mq = q5; ed = ed5; d = 5; af = 3; ae = 2; p = "d5";
      wr5 = w; rd5 = r; din5 = din; rst5_n = !rst;
    end else begin
      mq = q8; ed = ed8; d = 8; af = 7; ae = 1; p = "d8";
      wr8 = w; rd8 = r; din8 = din; rst8_n = !rst;
    end
    n = mq.size();
    wa = w && (n < d || r);
    ra = r && n > 0;
    if (rst) begin
      mq.delete(); ed = '0; e_ack = 0; e_ov = 0; e_un = 0;
    end else begin
      e_ack = wa; e_ov = w && !wa; e_un = r && !ra;
      if (ra) ed = mq.pop_front();
      if (wa) mq.push_back(din);
    end
    @(posedge clk);
    #1;
    vectors++;
    n = mq.size();
    chk({p, ".data_out"}, s ? 32'(dout5) : 32'(dout8), 32'(ed));
    chk({p, ".count"}, s ? 32'(cnt5) : 32'(cnt8), 32'(n));
    chk({p, ".full"}, s ? 32'(full5) : 32'(full8), 32'(n == d));
    chk({p, ".almostfull"}, s ? 32'(af5) : 32'(af8), 32'(n >= af && n < d));
    chk({p, ".empty"}, s ? 32'(em5) : 32'(em8), 32'(n == 0));
    chk({p, ".almostempty"}, s ? 32'(ae5) : 32'(ae8), 32'(n > 0 && n <= ae));
    chk({p, ".wr_ack"}, s ? 32'(ack5) : 32'(ack8), 32'(e_ack));
    chk({p, ".overflow"}, s ? 32'(ov5) : 32'(ov8), 32'(e_ov));
    chk({p, ".underflow"}, s ? 32'(un5) : 32'(un8), 32'(e_un));
    if (s) begin q5 = mq; ed5 = ed; end
    else begin q8 = mq; ed8 = ed; end
  endtask

  initial begin
    wr8 = 0; rd8 = 0; wr5 = 0; rd5 = 0; din8 = '0; din5 = '0;
    rst8_n = 0; rst5_n = 0;
    repeat (2) @(posedge clk);
    step(0, 1, 1, 16'hFFFF, 1);
    step(1, 1, 1, 16'hFFFF, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 16'hA000 + 16'(i), 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 16'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'hC000 + 16'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'hBEEF, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0, 0);
    step(0, 1, 1, 16'h1234, 0);
    step(0, 0, 1, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h7700 + 16'(i), 0);
    step(0, 1, 1, 16'h5555, 1);
    step(0, 1, 0, 16'h4321, 0);
    step(0, 0, 1, 16'h0, 0);
    for (int i = 0; i < 12; i++) step(1, i % 3 != 2, i >= 2, 16'h5000 + 16'(i), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h5100 + 16'(i), 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 16'h0, 0);
    for (int i = 0; i < 600; i++) begin
      bit s, w, r;
      s = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 99) < (i < 300 ? 65 : 40);
      r = $urandom_range(0, 99) < (i < 300 ? 40 : 65);
      step(s, w, r, 16'($urandom), $urandom_range(0, 79) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
